// File: rtl/button_hold_conditioner_if.sv
// Button conditioner signal bundle: raw pin in, debounced level and events out.
// Latency: none (wires only).
// Backpressure: none; events are single-cycle pulses the consumer must take.
interface button_hold_conditioner_if;
    logic btn_raw;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic hold_pulse;
    logic hold_active;

    // Conditioner side: samples the pin, drives the clean events.
    modport master (
        input  btn_raw,
        output btn_level,
        output press_pulse,
        output release_pulse,
        output hold_pulse,
        output hold_active
    );

    // Consumer/pin side: drives the pin, observes the events.
    modport slave (
        output btn_raw,
        input  btn_level,
        input  press_pulse,
        input  release_pulse,
        input  hold_pulse,
        input  hold_active
    );
endinterface

// File: rtl/button_hold_conditioner.sv
// Button conditioner: 2-flop sync, debouncer, press/hold classifier emitting clean events.
// Latency: stable raw change sampled at E0 shows on btn_level/press/release at E0+DB_CYCLES+1.
// Backpressure: none; pulses are one cycle wide and must be consumed when asserted.
module button_hold_conditioner #(
    parameter int CLK_FREQ_HZ    = 1000,
    parameter int DEBOUNCE_MS    = 20,
    parameter int HOLD_MS        = 5000,
    parameter bit BTN_ACTIVE_LOW = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    button_hold_conditioner_if.master   btn
);

    localparam int DB_RAW      = CLK_FREQ_HZ * DEBOUNCE_MS / 1000;
    localparam int DB_CYCLES   = (DB_RAW < 1) ? 1 : DB_RAW;
    localparam int HOLD_CYCLES = CLK_FREQ_HZ * HOLD_MS / 1000;
    localparam int DB_W        = $clog2(DB_CYCLES + 1);
    localparam int HOLD_W      = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);

    localparam logic              IDLE_PIN  = BTN_ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    // A zero-length long press has no meaning; refuse to build it.
    if (HOLD_CYCLES < 1) begin : g_hold_check
        $error("button_hold_conditioner: HOLD_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } state_t;

    logic              sync_meta;
    logic              sync_q;
    logic              btn_sync;
    logic              level_q;
    logic              level_nxt;
    logic [DB_W-1:0]   db_cnt;
    logic [DB_W-1:0]   db_cnt_nxt;
    state_t            state;
    state_t            state_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_cnt_nxt;
    logic              press_q;
    logic              release_q;
    logic              hold_q;
    logic              press_nxt;
    logic              release_nxt;
    logic              hold_nxt;

    // Two-flop synchroniser; reset parks both stages at the released pin value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= IDLE_PIN;
            sync_q    <= IDLE_PIN;
        end else begin
            sync_meta <= btn.btn_raw;
            sync_q    <= sync_meta;
        end
    end

    // Normalise so that 1 always means pressed downstream.
    assign btn_sync = BTN_ACTIVE_LOW ? ~sync_q : sync_q;

    // Debounce: count consecutive mismatching cycles, adopt the new level on the last one.
    always_comb begin
        level_nxt  = level_q;
        db_cnt_nxt = '0;
        if (btn_sync != level_q) begin
            if (db_cnt == DB_LAST) begin
                level_nxt = btn_sync;
            end else begin
                db_cnt_nxt = db_cnt + DB_W'(1);
            end
        end
    end

    // Debounced level and its counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_q <= 1'b0;
            db_cnt  <= '0;
        end else begin
            level_q <= level_nxt;
            db_cnt  <= db_cnt_nxt;
        end
    end

    // Classifier state, hold counter and registered event pulses. The FSM looks at
    // level_nxt so its events land on the same edge btn_level changes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            hold_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            hold_cnt  <= hold_cnt_nxt;
            press_q   <= press_nxt;
            release_q <= release_nxt;
            hold_q    <= hold_nxt;
        end
    end

    // Next state: a falling level always wins over reaching the hold terminal count.
    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        case (state)
            IDLE: begin
                if (level_nxt) begin
                    state_nxt    = PRESSED;
                    hold_cnt_nxt = '0;
                end
            end
            PRESSED: begin
                if (!level_nxt) begin
                    state_nxt = IDLE;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_nxt = HELD;
                end else begin
                    hold_cnt_nxt = hold_cnt + HOLD_W'(1);
                end
            end
            HELD: begin
                if (!level_nxt) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Event pulses are decoded from the transition about to be taken.
    always_comb begin
        press_nxt   = (state == IDLE) && (state_nxt == PRESSED);
        release_nxt = (state != IDLE) && (state_nxt == IDLE);
        hold_nxt    = (state == PRESSED) && (state_nxt == HELD);
    end

    assign btn.btn_level     = level_q;
    assign btn.press_pulse   = press_q;
    assign btn.release_pulse = release_q;
    assign btn.hold_pulse    = hold_q;
    assign btn.hold_active   = (state == HELD);

endmodule

// File: tb/tb_button_hold_conditioner.sv
// Directed bench for button_hold_conditioner across four parameterisations.
// Timing: inputs change 1 time unit after a rising edge; outputs are sampled there too.
// Pulses are also counted on falling edges to catch extra or overlapping events.
module tb_button_hold_conditioner;

    logic clk;
    logic reset_n;
    int   n_tests;
    int   n_fail;

    button_hold_conditioner_if if_def ();
    button_hold_conditioner_if if_h50 ();
    button_hold_conditioner_if if_h1 ();
    button_hold_conditioner_if if_ah ();

    button_hold_conditioner u_def (
        .clk     (clk),
        .reset_n (reset_n),
        .btn     (if_def)
    );

    button_hold_conditioner #(.HOLD_MS(50)) u_h50 (
        .clk     (clk),
        .reset_n (reset_n),
        .btn     (if_h50)
    );

    button_hold_conditioner #(.HOLD_MS(1)) u_h1 (
        .clk     (clk),
        .reset_n (reset_n),
        .btn     (if_h1)
    );

    button_hold_conditioner #(.BTN_ACTIVE_LOW(1'b0)) u_ah (
        .clk     (clk),
        .reset_n (reset_n),
        .btn     (if_ah)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pr_def, rl_def, hd_def;
    int pr_h50, rl_h50, hd_h50;
    int pr_ah, rl_ah, hd_ah;
    int overlap;

    // Event counters and overlap detector, sampled away from the active edge.
    always @(negedge clk) begin
        if (reset_n) begin
            pr_def += int'(if_def.press_pulse);
            rl_def += int'(if_def.release_pulse);
            hd_def += int'(if_def.hold_pulse);
            pr_h50 += int'(if_h50.press_pulse);
            rl_h50 += int'(if_h50.release_pulse);
            hd_h50 += int'(if_h50.hold_pulse);
            pr_ah  += int'(if_ah.press_pulse);
            rl_ah  += int'(if_ah.release_pulse);
            hd_ah  += int'(if_ah.hold_pulse);
            if (int'(if_def.press_pulse) + int'(if_def.release_pulse) + int'(if_def.hold_pulse) > 1)
                overlap++;
            if (int'(if_h50.press_pulse) + int'(if_h50.release_pulse) + int'(if_h50.hold_pulse) > 1)
                overlap++;
            if (int'(if_h1.press_pulse) + int'(if_h1.release_pulse) + int'(if_h1.hold_pulse) > 1)
                overlap++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        int b_pr, b_rl, b_hd;
        n_tests = 0;
        n_fail  = 0;
        pr_def = 0; rl_def = 0; hd_def = 0;
        pr_h50 = 0; rl_h50 = 0; hd_h50 = 0;
        pr_ah  = 0; rl_ah  = 0; hd_ah  = 0;
        overlap = 0;

        reset_n        = 1'b0;
        if_def.btn_raw = 1'b1;
        if_h50.btn_raw = 1'b1;
        if_h1.btn_raw  = 1'b1;
        if_ah.btn_raw  = 1'b0;
        tick(3);

        // Reset state
        chk("rst level", if_def.btn_level, 1'b0);
        chk("rst press", if_def.press_pulse, 1'b0);
        chk("rst release", if_def.release_pulse, 1'b0);
        chk("rst hold", if_def.hold_pulse, 1'b0);
        chk("rst hold_active", if_def.hold_active, 1'b0);
        reset_n = 1'b1;
        tick(5);

        // 1: clean press of 100 cycles
        b_pr = pr_def; b_rl = rl_def; b_hd = hd_def;
        if_def.btn_raw = 1'b0;
        tick(1);
        tick(20);
        chk("s1 level E0+20", if_def.btn_level, 1'b0);
        chk("s1 press E0+20", if_def.press_pulse, 1'b0);
        tick(1);
        chk("s1 level E0+21", if_def.btn_level, 1'b1);
        chk("s1 press E0+21", if_def.press_pulse, 1'b1);
        tick(1);
        chk("s1 press E0+22", if_def.press_pulse, 1'b0);
        tick(77);
        if_def.btn_raw = 1'b1;
        tick(1);
        tick(20);
        chk("s1 level R0+20", if_def.btn_level, 1'b1);
        chk("s1 release R0+20", if_def.release_pulse, 1'b0);
        tick(1);
        chk("s1 level R0+21", if_def.btn_level, 1'b0);
        chk("s1 release R0+21", if_def.release_pulse, 1'b1);
        tick(1);
        chk("s1 release R0+22", if_def.release_pulse, 1'b0);
        chk("s1 press count", pr_def - b_pr, 1);
        chk("s1 release count", rl_def - b_rl, 1);
        chk("s1 hold count", hd_def - b_hd, 0);
        tick(5);

        // 2: bounce every 5 cycles for 60 cycles, then hold low
        b_pr = pr_def;
        for (int i = 0; i < 12; i++) begin
            if_def.btn_raw = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick(5);
        end
        chk("s2 level during bounce", if_def.btn_level, 1'b0);
        if_def.btn_raw = 1'b0;
        tick(1);
        tick(20);
        chk("s2 level E0+20", if_def.btn_level, 1'b0);
        tick(1);
        chk("s2 level E0+21", if_def.btn_level, 1'b1);
        chk("s2 press E0+21", if_def.press_pulse, 1'b1);
        tick(10);
        chk("s2 press count", pr_def - b_pr, 1);
        if_def.btn_raw = 1'b1;
        tick(30);
        chk("s2 released", if_def.btn_level, 1'b0);

        // 3: long press of 6000 cycles
        b_pr = pr_def; b_rl = rl_def; b_hd = hd_def;
        if_def.btn_raw = 1'b0;
        tick(1);
        tick(21);
        chk("s3 press at P", if_def.press_pulse, 1'b1);
        tick(4999);
        chk("s3 hold P+4999", if_def.hold_pulse, 1'b0);
        chk("s3 hold_active P+4999", if_def.hold_active, 1'b0);
        tick(1);
        chk("s3 hold P+5000", if_def.hold_pulse, 1'b1);
        chk("s3 hold_active P+5000", if_def.hold_active, 1'b1);
        tick(1);
        chk("s3 hold P+5001", if_def.hold_pulse, 1'b0);
        chk("s3 hold_active P+5001", if_def.hold_active, 1'b1);
        tick(977);
        if_def.btn_raw = 1'b1;
        tick(1);
        tick(20);
        chk("s3 hold_active R0+20", if_def.hold_active, 1'b1);
        chk("s3 release R0+20", if_def.release_pulse, 1'b0);
        tick(1);
        chk("s3 release R0+21", if_def.release_pulse, 1'b1);
        chk("s3 hold_active R0+21", if_def.hold_active, 1'b0);
        tick(2);
        chk("s3 hold count", hd_def - b_hd, 1);
        chk("s3 release count", rl_def - b_rl, 1);
        tick(5);

        // 4a: HOLD 50, debounced fall lands on the terminal edge
        b_hd = hd_h50; b_rl = rl_h50;
        if_h50.btn_raw = 1'b0;
        tick(1);
        tick(21);
        chk("s4a press at P", if_h50.press_pulse, 1'b1);
        tick(28);
        if_h50.btn_raw = 1'b1;
        tick(1);
        tick(20);
        chk("s4a release P+49", if_h50.release_pulse, 1'b0);
        tick(1);
        chk("s4a release P+50", if_h50.release_pulse, 1'b1);
        chk("s4a hold P+50", if_h50.hold_pulse, 1'b0);
        tick(1);
        chk("s4a hold_active", if_h50.hold_active, 1'b0);
        chk("s4a hold count", hd_h50 - b_hd, 0);
        chk("s4a release count", rl_h50 - b_rl, 1);
        tick(5);

        // 4b: release one edge later
        b_hd = hd_h50;
        if_h50.btn_raw = 1'b0;
        tick(1);
        tick(21);
        chk("s4b press at P", if_h50.press_pulse, 1'b1);
        tick(29);
        if_h50.btn_raw = 1'b1;
        tick(1);
        tick(20);
        chk("s4b hold P+50", if_h50.hold_pulse, 1'b1);
        chk("s4b release P+50", if_h50.release_pulse, 1'b0);
        tick(1);
        chk("s4b release P+51", if_h50.release_pulse, 1'b1);
        chk("s4b hold P+51", if_h50.hold_pulse, 1'b0);
        chk("s4b hold_active P+51", if_h50.hold_active, 1'b0);
        tick(2);
        chk("s4b hold count", hd_h50 - b_hd, 1);
        tick(5);

        // HOLD_CYCLES = 1: hold one cycle after press
        if_h1.btn_raw = 1'b0;
        tick(1);
        tick(21);
        chk("h1 press at P", if_h1.press_pulse, 1'b1);
        chk("h1 hold at P", if_h1.hold_pulse, 1'b0);
        tick(1);
        chk("h1 hold P+1", if_h1.hold_pulse, 1'b1);
        chk("h1 press P+1", if_h1.press_pulse, 1'b0);
        chk("h1 hold_active P+1", if_h1.hold_active, 1'b1);
        if_h1.btn_raw = 1'b1;
        tick(25);
        chk("h1 hold_active released", if_h1.hold_active, 1'b0);

        // 5: reset mid-hold
        b_rl = rl_def;
        if_def.btn_raw = 1'b0;
        tick(1);
        tick(21);
        chk("s5 press at P", if_def.press_pulse, 1'b1);
        tick(2979);
        chk("s5 level before reset", if_def.btn_level, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("s5 level async", if_def.btn_level, 1'b0);
        chk("s5 hold_active async", if_def.hold_active, 1'b0);
        tick(3);
        reset_n = 1'b1;
        tick(1);
        tick(20);
        chk("s5 level E0+20", if_def.btn_level, 1'b0);
        tick(1);
        chk("s5 press E0+21", if_def.press_pulse, 1'b1);
        tick(4999);
        chk("s5 hold P+4999", if_def.hold_pulse, 1'b0);
        tick(1);
        chk("s5 hold P+5000", if_def.hold_pulse, 1'b1);
        chk("s5 no release on reset exit", rl_def - b_rl, 0);
        if_def.btn_raw = 1'b1;
        tick(25);
        chk("s5 released", if_def.btn_level, 1'b0);

        // 6: active-high pin, same timing as scenario 1
        b_pr = pr_ah; b_rl = rl_ah; b_hd = hd_ah;
        if_ah.btn_raw = 1'b1;
        tick(1);
        tick(20);
        chk("s6 level E0+20", if_ah.btn_level, 1'b0);
        tick(1);
        chk("s6 level E0+21", if_ah.btn_level, 1'b1);
        chk("s6 press E0+21", if_ah.press_pulse, 1'b1);
        tick(78);
        if_ah.btn_raw = 1'b0;
        tick(1);
        tick(20);
        chk("s6 release R0+20", if_ah.release_pulse, 1'b0);
        tick(1);
        chk("s6 release R0+21", if_ah.release_pulse, 1'b1);
        chk("s6 level R0+21", if_ah.btn_level, 1'b0);
        tick(2);
        chk("s6 press count", pr_ah - b_pr, 1);
        chk("s6 hold count", hd_ah - b_hd, 0);

        chk("no overlapping pulses", overlap, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/button_hold_conditioner.md
Name: button_hold_conditioner

Overview:
- Conditions one raw push-button for the digital lock: 2-flop synchroniser, debouncer, then a press/hold classifier FSM.
- Produces clean single-cycle press/release events for the keypad FSM.
- Produces a long-press indication (hold_pulse / hold_active) that feeds the lock's reset-hold stage as its reset request.
- Runs on the 1 kHz system tick clock.

Parameters:
- CLK_FREQ_HZ, 1000, clock frequency in Hz.
- DEBOUNCE_MS, 20, required stable time before the debounced level changes.
- HOLD_MS, 5000, continuous debounced-press time that qualifies as a long press.
- BTN_ACTIVE_LOW, 1, 1 = raw pin reads 0 when pressed; 0 = active-high pin.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- btn_raw  in  1  raw, asynchronous, bouncing button pin.
- btn_level  out  1  debounced level; 1 = pressed, regardless of BTN_ACTIVE_LOW.
- press_pulse  out  1  one-cycle pulse on debounced press.
- release_pulse  out  1  one-cycle pulse on debounced release.
- hold_pulse  out  1  one-cycle pulse when a press reaches HOLD_MS.
- hold_active  out  1  high from hold_pulse until the release is debounced.

Behaviour:
- Derived constants:
  - DB_CYCLES = max(1, CLK_FREQ_HZ*DEBOUNCE_MS/1000).
  - HOLD_CYCLES = CLK_FREQ_HZ*HOLD_MS/1000.
  - HOLD_CYCLES < 1 is an elaboration error.
  - Counter widths are $clog2(N+1); counters never wrap, they saturate or clear.
- Async reset (reset_n = 0):
  - Sync flops load the not-pressed pin value.
  - All counters = 0, FSM = IDLE.
  - All outputs = 0.
- Synchroniser:
  - btn_raw passes through 2 flops, then polarity is normalised (inverted when BTN_ACTIVE_LOW = 1).
  - Call the result btn_sync.
- Debouncer, per edge:
  - btn_sync == btn_level: db_cnt <= 0.
  - Mismatch and db_cnt == DB_CYCLES-1: btn_level <= btn_sync, db_cnt <= 0.
  - Mismatch otherwise: db_cnt++.
  - Latency: a raw change first sampled at edge E0 and held stable updates btn_level at edge E0+DB_CYCLES+1.
  - Any return to match before then restarts the count.
- FSM, registered, updates on the same edge btn_level changes:
  - IDLE: level rises -> PRESSED, press_pulse = 1, hold_cnt <= 0.
  - PRESSED, level falls: -> IDLE, release_pulse = 1.
  - PRESSED, level high and hold_cnt == HOLD_CYCLES-1: -> HELD, hold_pulse = 1, hold_active = 1.
  - PRESSED otherwise: hold_cnt++.
  - HELD, level falls: -> IDLE, release_pulse = 1, hold_active = 0.
  - HELD otherwise: stay, no further hold_pulse.
- Pulse timing:
  - hold_pulse occurs exactly HOLD_CYCLES edges after press_pulse.
  - All pulses are exactly one cycle wide and never overlap.
  - press_pulse is never followed by a second press_pulse without an intervening release_pulse.
- Boundaries:
  - Release and hold-terminal on the same edge: release wins, no hold_pulse.
  - Bounce shorter than DB_CYCLES while PRESSED/HELD: ignored, hold_cnt keeps counting.
  - Button held from reset deassertion: debounced normally, press_pulse after DB_CYCLES+1 edges.
  - reset_n asserted mid-hold: outputs drop immediately (async); no release_pulse is generated on exit from reset.
  - HOLD_CYCLES = 1: hold_pulse one cycle after press_pulse.

Test Plan:
1. Defaults (DB 20, HOLD 5000). Clean press of btn_raw = 0 for 100 cycles, first sampled at E0 -> btn_level = 1 at E0+21. press_pulse is one cycle at E0+21. release_pulse follows at 21 edges after btn_raw returns to 1. No hold_pulse.
2. Bounce: toggle btn_raw every 5 cycles for 60 cycles, then hold low -> btn_level rises exactly 21 edges after the last transition. Only one press_pulse.
3. Long press: btn_raw low for 6000 cycles -> hold_pulse 5000 edges after press_pulse. hold_active stays 1 until release_pulse at release+21. Exactly one hold_pulse.
4. Hold boundary: HOLD_MS = 50, release timed so the debounced fall lands on the terminal edge -> release_pulse only, no hold_pulse. Release one edge later -> hold_pulse, then release_pulse on the next edge.
5. Reset mid-hold: assert reset_n = 0 at 3000 cycles into a press -> all outputs 0 asynchronously. After deassertion with button still pressed -> press_pulse at +21, fresh 5000-cycle hold count.
6. BTN_ACTIVE_LOW = 0: repeat scenario 1 with inverted raw stimulus -> identical output timing.
